// File: rtl/background_code_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// background_code_gen : scrolling checkerboard background colour code, with side border and flash effect
// Rev 1.0
// ---------------------------------------------------------------------------
module background_code_gen #(
  parameter int TILE_LOG2    = 5,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BORDER_W     = 8,
  parameter int SCROLL_STEP  = 1,
  parameter int FLASH_FRAMES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        scrollEnable,
  input  logic        flashRequest,
  input  logic [1:0]  level,
  output logic [2:0]  generatedColorCode,
  output logic        flashActive
);

  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SCROLL = 2'd1;
  localparam logic [1:0] S_FLASH  = 2'd2;

  localparam logic [FC_W-1:0] C_LAST_FRAME = FC_W'(FLASH_FRAMES - 1);
  localparam logic [10:0]     C_W          = 11'(SCREEN_W);
  localparam logic [10:0]     C_H          = 11'(SCREEN_H);
  localparam logic [11:0]     C_H12        = 12'(SCREEN_H);
  localparam logic [10:0]     C_BORDER_L   = 11'(BORDER_W);
  localparam logic [10:0]     C_BORDER_R   = 11'(SCREEN_W - BORDER_W);
  localparam logic [10:0]     C_STEP       = 11'(SCROLL_STEP);

  logic [1:0]      state_q, state_d;
  logic [9:0]      scroll_offset_q, scroll_offset_d;
  logic [FC_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [2:0]      color_code_q, color_code_d;
  logic            flash_active_q, flash_active_d;

  logic [10:0] w_offset_sum;
  logic [10:0] w_offset_wrapped;
  logic [11:0] w_eff_y_raw;
  logic [11:0] w_eff_y;
  logic        w_parity;
  logic        w_blank;
  logic        w_border;
  logic        w_invert;
  logic [2:0]  w_visible;

  always_comb begin
    w_offset_sum     = {1'b0, scroll_offset_q} + C_STEP;
    w_offset_wrapped = (w_offset_sum >= C_H) ? (w_offset_sum - C_H) : w_offset_sum;

    state_d         = state_q;
    scroll_offset_d = scroll_offset_q;
    frame_cnt_d     = frame_cnt_q;

    // A flash request outranks frame-boundary processing, including the scroll step.
    if (flashRequest) begin
      state_d     = S_FLASH;
      frame_cnt_d = '0;
    end else if (startOfFrame) begin
      if (state_q == S_FLASH) begin
        if (frame_cnt_q == C_LAST_FRAME) begin
          state_d     = scrollEnable ? S_SCROLL : S_IDLE;
          frame_cnt_d = '0;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end else begin
        state_d = scrollEnable ? S_SCROLL : S_IDLE;
        if (state_q == S_SCROLL) begin
          scroll_offset_d = w_offset_wrapped[9:0];
        end
      end
    end

    flash_active_d = (state_d == S_FLASH);
  end

  always_comb begin
    w_eff_y_raw = {1'b0, pixelY} + {2'b00, scroll_offset_q};
    w_eff_y     = (w_eff_y_raw >= C_H12) ? (w_eff_y_raw - C_H12) : w_eff_y_raw;
    w_parity    = pixelX[TILE_LOG2] ^ w_eff_y[TILE_LOG2];
    w_blank     = (pixelX >= C_W) || (pixelY >= C_H);
    w_border    = (pixelX < C_BORDER_L) || (pixelX >= C_BORDER_R);
    w_invert    = (state_q == S_FLASH) && !frame_cnt_q[0];
    w_visible   = w_border ? 3'b111 : {level, w_parity};

    color_code_d = 3'b000;
    if (!w_blank) begin
      color_code_d = w_invert ? ~w_visible : w_visible;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      scroll_offset_q <= '0;
      frame_cnt_q     <= '0;
      color_code_q    <= 3'b000;
      flash_active_q  <= 1'b0;
    end else begin
      state_q         <= state_d;
      scroll_offset_q <= scroll_offset_d;
      frame_cnt_q     <= frame_cnt_d;
      color_code_q    <= color_code_d;
      flash_active_q  <= flash_active_d;
    end
  end

  assign generatedColorCode = color_code_q;
  assign flashActive        = flash_active_q;

endmodule
`default_nettype wire

// File: tb/tb_background_code_gen.sv
`default_nettype none
// Testbench for background_code_gen: vector table, directed sequences and random traffic vs. a frame-level model.
module tb_background_code_gen;

  localparam int W = 640;
  localparam int H = 480;
  localparam int BW = 8;
  localparam int TL = 5;
  localparam int STEP = 1;
  localparam int NF = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        scrollEnable;
  logic        flashRequest;
  logic [1:0]  level;
  logic [2:0]  generatedColorCode;
  logic        flashActive;

  background_code_gen #(
    .TILE_LOG2(TL), .SCREEN_W(W), .SCREEN_H(H), .BORDER_W(BW),
    .SCROLL_STEP(STEP), .FLASH_FRAMES(NF)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .scrollEnable(scrollEnable),
    .flashRequest(flashRequest), .level(level),
    .generatedColorCode(generatedColorCode), .flashActive(flashActive)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: offset in rows, scrolling intent, and flash frames still to run.
  int m_off = 0;
  bit m_scrolling = 0;
  int m_flash_left = 0;

  typedef struct {
    int x;
    int y;
    int lvl;
    int code;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int model_code(input int x, input int y, input int lvl);
    int ey, par, v;
    if (x >= W || y >= H) return 0;
    ey  = (y + m_off) % H;
    par = ((x >> TL) ^ (ey >> TL)) & 1;
    v   = (x < BW || x >= W - BW) ? 7 : (lvl * 2 + par);
    if (m_flash_left > 0 && ((NF - m_flash_left) % 2 == 0)) v = (~v) & 7;
    return v;
  endfunction

  task automatic model_step(input bit sof, input bit fr, input bit se);
    if (fr) begin
      m_flash_left = NF;
    end else if (sof) begin
      if (m_flash_left > 0) begin
        m_flash_left--;
        if (m_flash_left == 0) m_scrolling = se;
      end else begin
        if (m_scrolling) m_off = (m_off + STEP) % H;
        m_scrolling = se;
      end
    end
  endtask

  task automatic model_reset();
    m_off = 0;
    m_scrolling = 0;
    m_flash_left = 0;
  endtask

  // One clock: drive, predict, clock, compare both outputs against the model.
  task automatic cycle(input bit sof, input bit fr, input bit se, input int x, input int y, input int lvl);
    int exp_code, exp_fa;
    startOfFrame = sof;
    flashRequest = fr;
    scrollEnable = se;
    pixelX = 11'(x);
    pixelY = 11'(y);
    level  = 2'(lvl);
    exp_code = model_code(x, y, lvl);
    model_step(sof, fr, se);
    exp_fa = (m_flash_left > 0) ? 1 : 0;
    @(posedge clk);
    #1;
    check("code", int'(generatedColorCode), exp_code);
    check("flashActive", int'(flashActive), exp_fa);
  endtask

  initial begin
    bit rse;
    reset = 1'b1;
    startOfFrame = 0; flashRequest = 0; scrollEnable = 0;
    pixelX = 0; pixelY = 0; level = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_code", int'(generatedColorCode), 0);
    check("reset_flash", int'(flashActive), 0);
    @(negedge clk);
    reset = 1'b0;

    tbl[0] = '{8, 0, 2, 3'b100};
    tbl[1] = '{40, 0, 2, 3'b101};
    tbl[2] = '{40, 32, 2, 3'b100};
    tbl[3] = '{3, 10, 1, 3'b111};
    tbl[4] = '{635, 10, 1, 3'b111};
    tbl[5] = '{700, 10, 1, 3'b000};
    tbl[6] = '{100, 500, 1, 3'b000};
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 0, tbl[i].x, tbl[i].y, tbl[i].lvl);
      check($sformatf("tbl%0d", i), int'(generatedColorCode), tbl[i].code);
    end

    // Scroll: first pulse only enters SCROLL, following pulses step the offset.
    cycle(1, 0, 1, 8, 0, 0);
    for (int i = 0; i < 32; i++) cycle(1, 0, 1, 8, 0, 0);
    cycle(0, 0, 1, 8, 0, 0);
    check("scroll32", int'(generatedColorCode), 3'b001);
    for (int i = 0; i < 448; i++) cycle(1, 0, 1, 8, 0, 0);
    cycle(0, 0, 1, 8, 0, 0);
    check("scroll_wrap", int'(generatedColorCode), 3'b000);
    for (int i = 0; i < 470; i++) cycle(1, 0, 1, 8, 0, 0);
    cycle(0, 0, 1, 8, 20, 0);
    check("off470", int'(generatedColorCode), 3'b000);

    // Flash with alternating inversion, then exit into SCROLL.
    cycle(0, 1, 1, 8, 0, 0);
    cycle(0, 0, 1, 8, 0, 0);
    check("flash_f0", int'(generatedColorCode), 3'b111);
    for (int f = 0; f < NF; f++) begin
      cycle(0, 0, 1, 8, 0, 0);
      cycle(0, 0, 1, 8, 20, 0);
      cycle(1, 0, 1, 8, 0, 0);
    end
    cycle(0, 0, 1, 8, 0, 0);
    check("flash_exit", int'(flashActive), 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, 8, 26, 0);

    // Reset in the middle of a flash with offset 100.
    for (int i = 0; i < 1000 && m_off != 100; i++) cycle(1, 0, 1, 8, 0, 0);
    cycle(0, 1, 1, 8, 0, 0);
    cycle(0, 0, 1, 8, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_code", int'(generatedColorCode), 0);
    check("async_rst_flash", int'(flashActive), 0);
    model_reset();
    #1;
    reset = 1'b0;
    cycle(0, 0, 0, 8, 0, 0);
    check("post_rst", int'(generatedColorCode), 3'b000);
    cycle(1, 0, 0, 8, 26, 0);
    cycle(0, 0, 0, 8, 26, 0);
    check("post_rst_off0", int'(generatedColorCode), 3'b000);

    // Flash request coincident with a frame pulse at offset 5, restart at frame 6.
    cycle(1, 0, 1, 8, 26, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, 8, 26, 0);
    cycle(1, 1, 1, 8, 26, 0);
    cycle(0, 0, 1, 8, 26, 0);
    check("simul_off5_inv", int'(generatedColorCode), 3'b111);
    for (int f = 0; f < 6; f++) begin
      cycle(0, 0, 1, 8, 26, 0);
      cycle(1, 0, 1, 8, 26, 0);
    end
    cycle(0, 1, 1, 8, 26, 0);
    for (int f = 0; f < NF; f++) begin
      cycle(0, 0, 1, 8, 26, 0);
      cycle(1, 0, 1, 8, 26, 0);
      if (f == NF - 2) check("restart_active", int'(flashActive), 1);
    end
    cycle(0, 0, 1, 8, 26, 0);
    check("restart_done", int'(flashActive), 0);
    cycle(1, 0, 1, 8, 26, 0);
    cycle(0, 0, 1, 8, 26, 0);
    check("scroll_after_restart", int'(generatedColorCode), 3'b001);

    // Random traffic against the model.
    rse = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) rse = ~rse;
      cycle($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0, rse,
            int'($urandom_range(0, 799)), int'($urandom_range(0, 524)),
            int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
